// File: rtl/bus_host_seq.sv
// bus_host_seq: walks address ranges on a native parallel bus, writing a
// pattern to every address, reading it back and accumulating mismatches.
// Ports: clk, rst (sync, active high); start -> busy / done / pass;
//   r_wn, addr, wdata, rdata: native bus (r_wn=0 is a write strobe);
//   err_count (saturating), first_err_addr: result of the last run.
// Option: define BUS_HOST_SEQ_INV_PASS_EN for a second, inverted pass.
module bus_host_seq #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_RANGES   = 2,
    parameter int RANGES [NUM_RANGES][2] = '{'{0, 4}, '{8, 12}},
    parameter int READ_LATENCY = 0,
    parameter int ERR_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  r_wn,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);
    // One spare bit so that hi = 2**ADDR_WIDTH is representable.
    localparam int CW = ADDR_WIDTH + 1;
    localparam int IW = (NUM_RANGES > 1) ? $clog2(NUM_RANGES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_READ,
        S_WAIT, S_CHECK, S_NEXT, S_FINISH
    } state_e;

    state_e                state_q;
    logic [IW-1:0]         idx_q;
    logic [CW-1:0]         cur_q;
    logic [2:0]            wait_q;
    logic [DATA_WIDTH-1:0] smp_q;
    logic                  seen_q;
    logic                  r_wn_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;
    logic [ERR_WIDTH-1:0]  err_q;
    logic [ADDR_WIDTH-1:0] ferr_q;

    logic [CW-1:0] lo_d;
    logic [CW-1:0] hi_d;
    logic [CW-1:0] cur_d;
    logic          idx_last_d;
    logic          miss_d;
    logic          inv_d;
    logic          last_pass_d;

    assign lo_d       = CW'(RANGES[idx_q][0]);
    assign hi_d       = CW'(RANGES[idx_q][1]);
    assign cur_d      = cur_q + 1'b1;
    assign idx_last_d = (int'(idx_q) == NUM_RANGES - 1);
    // X/Z on the sampled read data must count as a mismatch.
    assign miss_d     = (smp_q !== wdata_q);

`ifdef BUS_HOST_SEQ_INV_PASS_EN
    logic inv_q;
    assign inv_d       = inv_q;
    assign last_pass_d = inv_q;
`else
    assign inv_d       = 1'b0;
    assign last_pass_d = 1'b1;
`endif

    function automatic logic [DATA_WIDTH-1:0] pat(
        input logic [CW-1:0] a,
        input logic          inv
    );
        logic [DATA_WIDTH-1:0] p;
        p = DATA_WIDTH'(a) + DATA_WIDTH'(1);
        return inv ? ~p : p;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cur_q   <= '0;
            wait_q  <= '0;
            smp_q   <= '0;
            seen_q  <= 1'b0;
            r_wn_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
`ifdef BUS_HOST_SEQ_INV_PASS_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                        err_q   <= '0;
                        ferr_q  <= '0;
                        pass_q  <= 1'b0;
                        seen_q  <= 1'b0;
                        idx_q   <= '0;
`ifdef BUS_HOST_SEQ_INV_PASS_EN
                        inv_q   <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    cur_q <= lo_d;
                    if (lo_d >= hi_d) begin
                        state_q <= S_NEXT;
                    end else begin
                        state_q <= S_WRITE;
                        r_wn_q  <= 1'b0;
                        addr_q  <= lo_d[ADDR_WIDTH-1:0];
                        wdata_q <= pat(lo_d, inv_d);
                    end
                end
                S_WRITE: begin
                    state_q <= S_READ;
                    r_wn_q  <= 1'b1;
                end
                S_READ: begin
                    if (READ_LATENCY == 0) begin
                        smp_q   <= rdata;
                        state_q <= S_CHECK;
                    end else begin
                        wait_q  <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_q == 3'(READ_LATENCY - 1)) begin
                        smp_q   <= rdata;
                        state_q <= S_CHECK;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (miss_d) begin
                        if (err_q != '1) err_q <= err_q + 1'b1;
                        if (!seen_q) ferr_q <= cur_q[ADDR_WIDTH-1:0];
                        seen_q <= 1'b1;
                    end
                    cur_q <= cur_d;
                    if (cur_d == hi_d) begin
                        state_q <= S_NEXT;
                    end else begin
                        state_q <= S_WRITE;
                        r_wn_q  <= 1'b0;
                        addr_q  <= cur_d[ADDR_WIDTH-1:0];
                        wdata_q <= pat(cur_d, inv_d);
                    end
                end
                S_NEXT: begin
                    if (idx_last_d && last_pass_d) begin
                        state_q <= S_FINISH;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0);
                    end else begin
                        state_q <= S_LOAD;
                        idx_q   <= idx_last_d ? '0 : idx_q + 1'b1;
`ifdef BUS_HOST_SEQ_INV_PASS_EN
                        if (idx_last_d) inv_q <= 1'b1;
`endif
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign r_wn           = r_wn_q;
    assign addr           = addr_q;
    assign wdata          = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_bus_host_seq.sv
// tb_bus_host_seq: randomized self-checking bench for bus_host_seq with two
// instances (default params; latency 3 / high ranges / 2-bit error count).
module tb_bus_host_seq;

    localparam int RA [2][2] = '{'{0, 4}, '{8, 12}};
    localparam int RB [2][2] = '{'{5, 5}, '{250, 256}};
`ifdef BUS_HOST_SEQ_INV_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    typedef struct {
        int         cyc;
        int         busy_low;
        int         nw;
        int         wr_bad;
        int         done_cnt;
        logic       pass;
        logic [7:0] err;
        logic [7:0] ferr;
        logic       busy_after;
        logic       done_after;
    } obs_t;

    typedef struct {
        int         cyc;
        int         nw;
        logic       pass;
        logic [7:0] err;
        logic [7:0] ferr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       startA, startB;
    logic       rwnA, rwnB;
    logic [7:0] addrA, addrB, wdataA, wdataB, rdataA, rdataB;
    logic       busyA, busyB, doneA, doneB, passA, passB;
    logic [7:0] errA, ferrA, ferrB;
    logic [1:0] errB;

    int n_cmp = 0;
    int n_bad = 0;
    int modeA = 0;
    int modeB = 0;
    int flip [2][256];
    logic [7:0] memA [256];
    logic [7:0] memB [256];
    logic [7:0] rawB, pb1, pb2, pb3;
    int obsA[$];
    int obsB[$];
    int expw[$];
    int doneA_cnt = 0;
    int doneB_cnt = 0;

    bus_host_seq dutA (
        .clk(clk), .rst(rst), .start(startA),
        .r_wn(rwnA), .addr(addrA), .wdata(wdataA), .rdata(rdataA),
        .busy(busyA), .done(doneA), .pass(passA),
        .err_count(errA), .first_err_addr(ferrA)
    );

    bus_host_seq #(
        .RANGES('{'{5, 5}, '{250, 256}}),
        .READ_LATENCY(3),
        .ERR_WIDTH(2)
    ) dutB (
        .clk(clk), .rst(rst), .start(startB),
        .r_wn(rwnB), .addr(addrB), .wdata(wdataB), .rdata(rdataB),
        .busy(busyB), .done(doneB), .pass(passB),
        .err_count(errB), .first_err_addr(ferrB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus targets: plain memories, with an optional read-side fault.
    always @(posedge clk) begin
        if (rwnA === 1'b0) memA[addrA] <= wdataA;
        if (rwnB === 1'b0) memB[addrB] <= wdataB;
        pb1 <= rawB;
        pb2 <= pb1;
        pb3 <= pb2;
    end

    always_comb begin
        rdataA = memA[addrA];
        case (modeA)
            1: if (addrA == 8'd2) rdataA = memA[addrA] & 8'hFE;
            2: rdataA = 8'h00;
            3: rdataA = memA[addrA] ^ 8'(flip[0][addrA]);
            default: ;
        endcase
    end

    always_comb begin
        rawB = memB[addrB];
        case (modeB)
            1: if (addrB == 8'd2) rawB = memB[addrB] & 8'hFE;
            2: rawB = 8'h00;
            3: rawB = memB[addrB] ^ 8'(flip[1][addrB]);
            default: ;
        endcase
    end

    assign rdataB = pb3;

    always @(negedge clk) begin
        if (rwnA === 1'b0) obsA.push_back(int'({addrA, wdataA}));
        if (rwnB === 1'b0) obsB.push_back(int'({addrB, wdataB}));
        if (doneA === 1'b1) doneA_cnt++;
        if (doneB === 1'b1) doneB_cnt++;
    end

    function automatic int readback(input int which, input int a, input int d);
        int m;
        m = which ? modeB : modeA;
        case (m)
            1: return (a == 2) ? (d & 254) : d;
            2: return 0;
            3: return d ^ flip[which][a];
            default: return d;
        endcase
    endfunction

    // Expected run: every address of every range in order, every pass.
    task automatic model(input int which, output exp_t e);
        int cnt, first, n, lo, hi, d, lat, emax;
        cnt = 0; first = -1; n = 0;
        lat = which ? 3 : 0;
        emax = which ? 3 : 255;
        expw.delete();
        for (int p = 0; p < NPASS; p++) begin
            for (int r = 0; r < 2; r++) begin
                lo = which ? RB[r][0] : RA[r][0];
                hi = which ? RB[r][1] : RA[r][1];
                for (int a = lo; a < hi; a++) begin
                    d = (a + 1) % 256;
                    if (p == 1) d = 255 - d;
                    expw.push_back(a * 256 + d);
                    if (readback(which, a, d) != d) begin
                        cnt++;
                        if (first < 0) first = a;
                    end
                    n++;
                end
            end
        end
        e.cyc  = n * (3 + lat) + NPASS * 4 + 1;
        e.nw   = n;
        e.pass = (cnt == 0);
        e.err  = 8'((cnt > emax) ? emax : cnt);
        e.ferr = 8'((first < 0) ? 0 : first);
    endtask

    // Drives one run (with a start poke while busy) and collects observations.
    task automatic run_seq(input int which, input int poke, output obs_t o);
        int n;
        int got[$];
        o = '{default: 0};
        @(negedge clk);
        obsA.delete(); obsB.delete();
        doneA_cnt = 0; doneB_cnt = 0;
        if (which != 0) startB = 1'b1; else startA = 1'b1;
        @(negedge clk);
        startA = 1'b0; startB = 1'b0;
        n = 1;
        while (((which != 0) ? doneB : doneA) !== 1'b1 && n < 500) begin
            if (((which != 0) ? busyB : busyA) !== 1'b1) o.busy_low++;
            if (n == poke) begin
                if (which != 0) startB = 1'b1; else startA = 1'b1;
            end
            @(negedge clk);
            startA = 1'b0; startB = 1'b0;
            n++;
        end
        o.cyc = n;
        @(negedge clk);
        if (which != 0) begin
            got = obsB;
            o.busy_after = busyB; o.done_after = doneB; o.pass = passB;
            o.err = {6'd0, errB}; o.ferr = ferrB; o.done_cnt = doneB_cnt;
        end else begin
            got = obsA;
            o.busy_after = busyA; o.done_after = doneA; o.pass = passA;
            o.err = errA; o.ferr = ferrA; o.done_cnt = doneA_cnt;
        end
        o.nw = got.size();
        o.wr_bad = -1;
        for (int i = 0; i < o.nw; i++)
            if (o.wr_bad < 0 && (i >= expw.size() || got[i] != expw[i])) o.wr_bad = i;
    endtask

    task automatic test_reset();
        rst = 1'b1; startA = 1'b1; startB = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({rwnA, addrA, wdataA} !== {1'b1, 16'h0}) begin n_bad++; $display("FAIL reset.busA got %h want 10000", {rwnA, addrA, wdataA}); end
        n_cmp++; if ({busyA, doneA, passA, errA, ferrA} !== 19'h0) begin n_bad++; $display("FAIL reset.statA got %h want 0", {busyA, doneA, passA, errA, ferrA}); end
        n_cmp++; if ({rwnB, addrB, wdataB} !== {1'b1, 16'h0}) begin n_bad++; $display("FAIL reset.busB got %h want 10000", {rwnB, addrB, wdataB}); end
        n_cmp++; if ({busyB, doneB, passB, errB, ferrB} !== 13'h0) begin n_bad++; $display("FAIL reset.statB got %h want 0", {busyB, doneB, passB, errB, ferrB}); end
        startA = 1'b0; startB = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busyA, busyB} !== 2'b00) begin n_bad++; $display("FAIL reset.start_ignored got %b want 00", {busyA, busyB}); end
    endtask

    task automatic test_ideal();
        obs_t o; exp_t e;
        modeA = 0;
        model(0, e);
        run_seq(0, $urandom_range(2, 20), o);
        n_cmp++; if (o.cyc !== e.cyc) begin n_bad++; $display("FAIL ideal.cycles got %0d want %0d", o.cyc, e.cyc); end
        n_cmp++; if (o.busy_low !== 0) begin n_bad++; $display("FAIL ideal.busy_low got %0d want 0", o.busy_low); end
        n_cmp++; if (o.nw !== e.nw) begin n_bad++; $display("FAIL ideal.nwrites got %0d want %0d", o.nw, e.nw); end
        n_cmp++; if (o.wr_bad !== -1) begin n_bad++; $display("FAIL ideal.write_seq bad index %0d want -1", o.wr_bad); end
        n_cmp++; if (o.done_cnt !== 1) begin n_bad++; $display("FAIL ideal.done_pulses got %0d want 1", o.done_cnt); end
        n_cmp++; if ({o.busy_after, o.done_after} !== 2'b00) begin n_bad++; $display("FAIL ideal.after got %b want 00", {o.busy_after, o.done_after}); end
        n_cmp++; if ({o.pass, o.err, o.ferr} !== {e.pass, e.err, e.ferr}) begin n_bad++; $display("FAIL ideal.result got %h want %h", {o.pass, o.err, o.ferr}, {e.pass, e.err, e.ferr}); end
    endtask

    task automatic test_stuck_bit();
        obs_t o; exp_t e;
        modeA = 1;
        model(0, e);
        run_seq(0, $urandom_range(2, 20), o);
        n_cmp++; if (o.cyc !== e.cyc) begin n_bad++; $display("FAIL stuck.cycles got %0d want %0d", o.cyc, e.cyc); end
        n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL stuck.err got %0d want %0d", o.err, e.err); end
        n_cmp++; if (o.ferr !== e.ferr) begin n_bad++; $display("FAIL stuck.first got %0d want %0d", o.ferr, e.ferr); end
        n_cmp++; if (o.pass !== e.pass) begin n_bad++; $display("FAIL stuck.pass got %b want %b", o.pass, e.pass); end
        modeA = 0;
    endtask

    task automatic test_latency_wrap();
        obs_t o; exp_t e;
        modeB = 0;
        model(1, e);
        run_seq(1, $urandom_range(2, 20), o);
        n_cmp++; if (o.cyc !== e.cyc) begin n_bad++; $display("FAIL lat.cycles got %0d want %0d", o.cyc, e.cyc); end
        n_cmp++; if (o.nw !== e.nw) begin n_bad++; $display("FAIL lat.nwrites got %0d want %0d", o.nw, e.nw); end
        n_cmp++; if (o.wr_bad !== -1) begin n_bad++; $display("FAIL lat.write_seq bad index %0d want -1", o.wr_bad); end
        n_cmp++; if (o.busy_low !== 0) begin n_bad++; $display("FAIL lat.busy_low got %0d want 0", o.busy_low); end
        n_cmp++; if ({o.pass, o.err} !== {e.pass, e.err}) begin n_bad++; $display("FAIL lat.result got %h want %h", {o.pass, o.err}, {e.pass, e.err}); end
    endtask

    task automatic test_saturate();
        obs_t o; exp_t e;
        for (int w = 0; w < 2; w++) begin
            if (w != 0) modeB = 2; else modeA = 2;
            model(w, e);
            run_seq(w, $urandom_range(2, 20), o);
            n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL sat%0d.err got %0d want %0d", w, o.err, e.err); end
            n_cmp++; if (o.ferr !== e.ferr) begin n_bad++; $display("FAIL sat%0d.first got %0d want %0d", w, o.ferr, e.ferr); end
            n_cmp++; if (o.pass !== e.pass) begin n_bad++; $display("FAIL sat%0d.pass got %b want %b", w, o.pass, e.pass); end
        end
        modeA = 0; modeB = 0;
    endtask

    task automatic test_random();
        obs_t o; exp_t e; int w;
        for (int it = 0; it < 8; it++) begin
            w = $urandom_range(0, 1);
            for (int a = 0; a < 256; a++)
                flip[w][a] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
            if (w != 0) modeB = 3; else modeA = 3;
            model(w, e);
            run_seq(w, $urandom_range(2, 20), o);
            n_cmp++; if (o.cyc !== e.cyc) begin n_bad++; $display("FAIL rand%0d.cycles got %0d want %0d", it, o.cyc, e.cyc); end
            n_cmp++; if (o.wr_bad !== -1 || o.nw !== e.nw) begin n_bad++; $display("FAIL rand%0d.writes got %0d/%0d want -1/%0d", it, o.wr_bad, o.nw, e.nw); end
            n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL rand%0d.err got %0d want %0d", it, o.err, e.err); end
            n_cmp++; if (o.ferr !== e.ferr) begin n_bad++; $display("FAIL rand%0d.first got %0d want %0d", it, o.ferr, e.ferr); end
            n_cmp++; if (o.pass !== e.pass) begin n_bad++; $display("FAIL rand%0d.pass got %b want %b", it, o.pass, e.pass); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        modeA = 0; modeB = 0;
    endtask

    task automatic test_reset_midrun();
        obs_t o; exp_t e; int n;
        modeA = 0;
        @(negedge clk);
        doneA_cnt = 0;
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        n = 0;
        while (!(rwnA === 1'b0 && addrA === 8'd9) && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (n >= 60) begin n_bad++; $display("FAIL midrun.find_write9 got timeout want write of addr 9"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({busyA, rwnA, doneA} !== 3'b010) begin n_bad++; $display("FAIL midrun.abort got %b want 010", {busyA, rwnA, doneA}); end
        n_cmp++; if ({addrA, wdataA, errA, ferrA} !== 32'h0) begin n_bad++; $display("FAIL midrun.cleared got %h want 0", {addrA, wdataA, errA, ferrA}); end
        repeat (3) @(negedge clk);
        n_cmp++; if (doneA_cnt !== 0) begin n_bad++; $display("FAIL midrun.no_done got %0d want 0", doneA_cnt); end
        model(0, e);
        run_seq(0, 7, o);
        n_cmp++; if (o.cyc !== e.cyc) begin n_bad++; $display("FAIL midrun.rerun_cycles got %0d want %0d", o.cyc, e.cyc); end
        n_cmp++; if (o.wr_bad !== -1) begin n_bad++; $display("FAIL midrun.rerun_writes bad index %0d want -1", o.wr_bad); end
        n_cmp++; if (o.pass !== 1'b1) begin n_bad++; $display("FAIL midrun.rerun_pass got %b want 1", o.pass); end
    endtask

    initial begin
        rst = 1'b1; startA = 1'b0; startB = 1'b0;
        for (int w = 0; w < 2; w++)
            for (int a = 0; a < 256; a++) flip[w][a] = 0;
        test_reset();
        test_ideal();
        test_stuck_bit();
        test_latency_wrap();
        test_saturate();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
